// File: rtl/alu_stream_unit.sv
// Valid/ready request front end around the 32-bit alu, with an in-order response buffer.
// Latency: accept at edge N -> rsp_valid after N+1; req_ready is state-only and reserves a slot for s1.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  f,
  output logic [31:0] y,
  output logic [3:0]  flags
);
  logic [31:0] bb;
  logic [32:0] sum;
  logic        ovf;
  logic        arith;

  // f[2] inverts b and supplies the carry-in, turning ADD into SUB and AND/OR into AND-NOT/OR-NOT
  always_comb begin
    bb    = f[2] ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bb} + {32'd0, f[2]};
    ovf   = (a[31] == bb[31]) && (sum[31] != a[31]);
    arith = (f[1:0] == 2'b10);
    case (f[1:0])
      2'b00:   y = a & bb;
      2'b01:   y = a | bb;
      2'b10:   y = sum[31:0];
      default: y = {31'd0, sum[31] ^ ovf};
    endcase
    flags = {(y == 32'd0), arith & ovf, arith & sum[32], y[31]};
  end
endmodule

module alu_stream_unit #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  input  logic [2:0]               req_f,
  input  logic [TAGW-1:0]          req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [3:0]               rsp_flags,
  output logic [TAGW-1:0]          rsp_tag,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              ops_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     result;
    logic [3:0]      flags;
    logic [TAGW-1:0] tag;
  } entry_t;

  logic            s1_valid;
  logic [31:0]     s1_a;
  logic [31:0]     s1_b;
  logic [2:0]      s1_f;
  logic [TAGW-1:0] s1_tag;
  logic [31:0]     alu_y;
  logic [3:0]      alu_flags;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            req_fire;
  logic            pop;
  entry_t          head;

  alu u_alu (
    .a     (s1_a),
    .b     (s1_b),
    .f     (s1_f),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // s1 counts against capacity so its write next edge always has a free slot
  assign req_ready = ({1'b0, count} + {{CW{1'b0}}, s1_valid}) < (CW+1)'(DEPTH);
  assign occupancy = count + {{AW{1'b0}}, s1_valid};
  assign req_fire  = req_valid && req_ready;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign head       = mem[rd_ptr];
  assign rsp_result = head.result;
  assign rsp_flags  = head.flags;
  assign rsp_tag    = head.tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= '0;
      s1_tag   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ops_done <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (s1_valid) begin
        mem[wr_ptr] <= '{result: alu_y, flags: alu_flags, tag: s1_tag};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      s1_valid <= req_fire;
      if (req_fire) begin
        s1_a   <= req_a;
        s1_b   <= req_b;
        s1_f   <= req_f;
        s1_tag <= req_tag;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        ops_done <= ops_done + 32'd1;
      end
      case ({s1_valid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/alu_stream_unit.md
# alu_stream_unit

Request/response front end for the 32-bit `alu` datapath. It accepts operand/function requests over a valid/ready handshake and instantiates `alu` internally. It registers the ALU result with its four flags and returns them in request order through a DEPTH-entry response buffer with backpressure. It is the responder side of the vector-driven ALU interface, so sequencers, loaders or a host port can stream operations without timing the combinational `alu` themselves.

## Interface
- DEPTH, 4: response buffer entries; power of 2, ≥2
- TAGW, 8: width of the opaque request tag
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_a  in  32  operand a
- req_b  in  32  operand b
- req_f  in  3  ALU function select, passed unchanged to `alu.f`
- req_tag  in  TAGW  opaque ID, returned with the response
- rsp_valid  out  1  response at head of buffer
- rsp_ready  in  1  consumer takes response
- rsp_result  out  32  ALU result
- rsp_flags  out  4  {zero, overflow, carry, negative} from `alu`
- rsp_tag  out  TAGW  tag of the originating request
- occupancy  out  $clog2(DEPTH)+1  s1_valid + buffered entries
- ops_done  out  32  count of responses consumed

## Operation
- Transfer rules:
  - Request transfer: edge with req_valid && req_ready.
  - Response transfer: edge with rsp_valid && rsp_ready.
- Stage 1 (s1):
  - On a request transfer, s1 registers a, b, f and tag, and sets s1_valid.
  - s1 drives the `alu` instance directly. No request input reaches `alu` combinationally.
- Stage 2 (buffer):
  - On each edge where s1_valid=1, {result, flags, tag} from the `alu` outputs on s1 is written to the buffer tail.
  - s1_valid then takes the value of the new request transfer, or 0 if none.
- Buffer:
  - Circular, with DEPTH entries, wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register.
  - rsp_* come straight from the entry at rd_ptr. rsp_valid = (count != 0).
- req_ready = (count + s1_valid) < DEPTH.
  - It depends on state only: no combinational path from rsp_ready or req_valid.
  - Credit is reserved for s1, so a buffer write never finds the buffer full.
- Simultaneous write and pop: both take effect, count is unchanged, and the pointers advance independently. This includes count==DEPTH-1 with a write and a pop on the same edge.
- Pop with count==0 cannot occur, because rsp_valid=0.
- Ordering: responses leave in strict request order, with no reordering and no drops.
- ops_done increments on each response transfer and wraps 0xFFFFFFFF→0.
- occupancy = count + s1_valid.
- Flags pass from `alu` unmodified. The unit does not interpret f. Per `alu`, f=010 is ADD and f=110 is SUB.
- While rsp_valid=1 and rsp_ready=0, rsp_* hold stable.

## Timing
- Reset:
  - s1_valid=0, count=0, wr_ptr=rd_ptr=0, ops_done=0.
  - rsp_valid=0, occupancy=0, req_ready=1.
  - rsp_result, rsp_flags and rsp_tag show buffer entry 0, which reset clears to 0.
- Latency: a request accepted at edge N sets rsp_valid after edge N+1. With rsp_ready=1, the response is consumed at edge N+2.
- Throughput: 1 request/cycle sustained while rsp_ready=1.
- Full: occupancy==DEPTH forces req_ready=0. A pop at edge M gives req_ready=1 after M.
- Reset asserted mid-stream wins over any transfer on that edge:
  - in-flight s1 and buffered entries are discarded;
  - ops_done clears;
  - outputs take reset values after the edge.
- req_valid while req_ready=0: no state change. The requester must hold the request.

## Test plan
- ADD overflow:
  - Stimulus: a=0x7FFFFFFF, b=0x00000001, f=010, tag=0x11; rsp_ready=1.
  - Required response: after 2nd edge, rsp_result=0x80000000, flags=0101 (V=1, N=1), tag=0x11, ops_done=1.
- SUB to zero:
  - Stimulus: a=b=0x12345678, f=110.
  - Required response: rsp_result=0, flags=1010 (Z=1, C=1).
- Back-to-back stream:
  - Stimulus: 8 requests, tags 0..7, a=tag, b=1, f=010; rsp_ready=1.
  - Required response: results 1..8 in order, one per cycle, with no bubbles after the first.
- Backpressure and full:
  - Stimulus: rsp_ready=0, 6 requests offered with DEPTH=4.
  - Required response:
    - exactly 4 accepted, then req_ready=0 and occupancy=4;
    - rsp_* stable;
    - after rsp_ready=1, all 6 complete in order.
- Simultaneous push/pop at count=3:
  - Required response: count stays 3 and no entry is lost across pointer wrap. Run for ≥10 entries.
- Reset mid-stream:
  - Stimulus: reset asserted with occupancy=3.
  - Required response: next cycle rsp_valid=0, occupancy=0, ops_done=0, req_ready=1. A subsequent request completes with correct data.
